// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides.
// Both ends import these defaults so their bit timing agrees.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic IDLE_LEVEL = 1'b1;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running per-bit cycle counter with synchronous clear.
// Flags the last cycle of a bit and the cycle just before it.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end,
    output logic near_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] NEAR = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_end  = (count == LAST);
    assign near_end = (count == NEAR);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one word per valid/ready handshake, sent as
// start bit, DATA_BITS data bits LSB first, one stop bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic [1:0]           state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IW-1:0]        bit_idx;
    logic                 bit_end;
    logic                 near_end;
    logic                 accept;

    assign accept = (state == IDLE) && tx_valid;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .bit_end  (bit_end),
        .near_end (near_end)
    );

    // Outputs are registered: each one is loaded with its value for the
    // state being entered, so the line never depends on tx_valid/tx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_serial <= IDLE_LEVEL;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= (state == STOP) && near_end;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= START;
                        shift_reg <= tx_data;
                        bit_idx   <= '0;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                        tx_serial <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state     <= DATA;
                        tx_serial <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_IDX) begin
                            state     <= STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                            bit_idx   <= bit_idx + 1'b1;
                            tx_serial <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state     <= IDLE;
                        tx_ready  <= 1'b1;
                        tx_busy   <= 1'b0;
                        tx_serial <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                    tx_serial <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
